imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter: CNT_W, 16, width of error counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 imm_sel  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 I-unsigned, 110 S-unsigned, 111 B-unsigned.
REQ-008 imm  input  32  immediate value to encode.
REQ-009 base_instr  input  32  template; supplies every non-immediate bit.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 instr  output  32  encoded instruction.
REQ-013 range_err  output  1  imm not representable in imm_sel format; qualifies instr.
REQ-014 clr_cnt  input  1  synchronous clear of err_count.
REQ-015 err_count  output  CNT_W  saturating count of erroneous results delivered.

Function
REQ-016 Packing SHALL be: I/I-u [31:20]=imm[11:0]; S/S-u [31:25]=imm[11:5], [11:7]=imm[4:0]; B/B-u [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; U [31:12]=imm[31:12]; J [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; all other bits from base_instr.
REQ-017 Range rules SHALL be: I,S imm[31:11] all equal; B imm[0]==0 and imm[31:12] all equal; U imm[11:0]==0; J imm[0]==0 and imm[31:20] all equal; I-u,S-u imm[31:12]==0; B-u imm[31:13]==0 and imm[0]==0.
REQ-018 On range error, instr SHALL still carry the truncated packing of REQ-016 and range_err=1.
REQ-019 Re-extending a non-error instr by the same format SHALL reproduce imm exactly.
REQ-020 Datapath SHALL be a two-stage pipeline: S1 registers packed word plus range flag; S2 is the output register.
REQ-021 Transfer occurs on valid&&ready at each boundary; latency in_valid&&in_ready at edge N -> out_valid at edge N+2 when unstalled.
REQ-022 Throughput SHALL be one request per cycle with out_ready held high.
REQ-023 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; S1 advances when S2 is empty or S2 drains (out_valid&&out_ready).
REQ-024 in_ready SHALL NOT depend combinationally on in_valid.
REQ-025 While out_valid=1 and out_ready=0, instr and range_err SHALL hold stable and no request SHALL be lost or duplicated.
REQ-026 err_count SHALL increment by one on each out_valid&&out_ready&&range_err, saturating at all-ones.
REQ-027 clr_cnt coinciding with an increment SHALL yield err_count=0 (clear wins).

Reset
REQ-028 On rst: S1/S2 valid=0, out_valid=0, instr=0, range_err=0, err_count=0; in_ready=1 the cycle after rst deasserts.
REQ-029 rst mid-operation SHALL discard in-flight requests; no output for them after reset.

Structure
REQ-030 A shared package SHALL hold imm_sel encodings and CNT_W default.
REQ-031 Range checking SHALL be one combinational sub-module, imm_range_check (imm, imm_sel -> ok).

Verification
REQ-032 I, imm=0xFFFFF800 (-2048), base_instr=0x00000013 -> instr=0x80000013, range_err=0, two cycles later.
REQ-033 B, imm=0x00000801 (odd) -> range_err=1, err_count 0->1 on delivery.
REQ-034 J, imm=0x000FFFFE, base 0x0000006F -> instr=0x7FFFF06F... verify by re-extension (REQ-019) equals imm, range_err=0.
REQ-035 Back-to-back 8 requests, out_ready low 3 cycles mid-stream -> all 8 delivered in order, stable during stall, in_ready low when both stages full.
REQ-036 err_count preset to all-ones via errors (CNT_W=4: 16 errors) -> holds 0xF; clr_cnt with simultaneous error -> 0.
REQ-037 rst asserted with both stages full -> out_valid=0 next cycle, err_count=0, no stale output afterward.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: format encodings, defaults,
// the intermediate result record and the immediate-packing helper.
package imm_encoder_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int STAGES    = 2;

  typedef enum logic [2:0] {
    SEL_I  = 3'b000,
    SEL_S  = 3'b001,
    SEL_B  = 3'b010,
    SEL_U  = 3'b011,
    SEL_J  = 3'b100,
    SEL_IU = 3'b101,
    SEL_SU = 3'b110,
    SEL_BU = 3'b111
  } imm_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_res_t;

  // Scatter the immediate into its format's bit slots; everything else
  // comes from the template. Out-of-range immediates are simply truncated.
  function automatic logic [31:0] imm_pack(input logic [2:0]  sel,
                                           input logic [31:0] imm,
                                           input logic [31:0] base);
    logic [31:0] w;
    w = base;
    case (imm_sel_e'(sel))
      SEL_I, SEL_IU: w[31:20] = imm[11:0];
      SEL_S, SEL_SU: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      SEL_B, SEL_BU: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      SEL_U: w[31:12] = imm[31:12];
      SEL_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: w = base;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_encoder_range.sv
// Combinational representability check of an immediate in a given format.
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_sel,
  output logic        ok
);

  logic sx11, sx12, sx20;

  // Sign-extension checks: the upper bits must all copy the format's sign bit.
  assign sx11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign sx12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign sx20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    ok = 1'b0;
    case (imm_sel_e'(imm_sel))
      SEL_I, SEL_S:   ok = sx11;
      SEL_B:          ok = sx12 & ~imm[0];
      SEL_U:          ok = ~(|imm[11:0]);
      SEL_J:          ok = sx20 & ~imm[0];
      SEL_IU, SEL_SU: ok = ~(|imm[31:12]);
      SEL_BU:         ok = ~(|imm[31:13]) & ~imm[0];
      default:        ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 packs and range-checks, S2 is the output
// register, with valid/ready flow control and a saturating error counter.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_sel,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             range_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_count
);

  logic [STAGES-1:0] vld_pipe;   // [0] = S1 occupied, [1] = S2 occupied
  enc_res_t          s1_q, s2_q;
  logic              ok;
  logic              s1_adv;
  logic              deliver;

  imm_range_check u_rng (
    .imm     (imm),
    .imm_sel (imm_sel),
    .ok      (ok)
  );

  assign out_valid = vld_pipe[1];
  assign deliver   = out_valid & out_ready;
  assign s1_adv    = ~vld_pipe[1] | out_ready;
  // Depends only on stage occupancy and out_ready, never on in_valid.
  assign in_ready  = ~vld_pipe[0] | s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (in_ready) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) begin
          s1_q.instr <= imm_pack(imm_sel, imm, base_instr);
          s1_q.err   <= ~ok;
        end
      end
      if (s1_adv) begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) s2_q <= s1_q;
      end
    end
  end

  assign instr     = s2_q.instr;
  assign range_err = s2_q.err;

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)
      err_count <= '0;
    else if (deliver && s2_q.err && (err_count != {CNT_W{1'b1}}))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table plus stall, saturation and reset sequences.
module tb_imm_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, range_err, clr_cnt;
  logic [2:0]    imm_sel;
  logic [31:0]   imm, base_instr, instr;
  logic [CW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  imm_encoder #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_sel    (imm_sel),
    .imm        (imm),
    .base_instr (base_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .range_err  (range_err),
    .clr_cnt    (clr_cnt),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vec[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Independent decode of the immediate back out of an instruction word.
  function automatic logic [31:0] reext(input logic [31:0] w, input logic [2:0] sel);
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    i12 = w[31:20];
    case (sel)
      3'd0: reext = {{20{i12[11]}}, i12};
      3'd5: reext = {20'd0, i12};
      3'd1: begin i12 = {w[31:25], w[11:7]}; reext = {{20{i12[11]}}, i12}; end
      3'd6: begin i12 = {w[31:25], w[11:7]}; reext = {20'd0, i12}; end
      3'd2: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; reext = {{19{b13[12]}}, b13}; end
      3'd7: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; reext = {19'd0, b13}; end
      3'd3: reext = {w[31:12], 12'd0};
      default: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; reext = {{11{j21[20]}}, j21}; end
    endcase
  endfunction

  task automatic send_errs(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1; imm_sel = 3'd5; imm = 32'h0000_1000; base_instr = 32'h13;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          exp_cnt;
    int          sent, got;
    bit          prev_stall, saw_full;
    logic [31:0] prev;

    vec[0]  = '{3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0};
    vec[1]  = '{3'd2, 32'h0000_0801, 32'h0000_0063, 32'h0000_00E3, 1'b1};
    vec[2]  = '{3'd4, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0};
    vec[3]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_2023, 32'hFE00_2FA3, 1'b0};
    vec[4]  = '{3'd3, 32'h1234_5000, 32'h0000_0537, 32'h1234_5537, 1'b0};
    vec[5]  = '{3'd3, 32'h1234_5678, 32'h0000_0037, 32'h1234_5037, 1'b1};
    vec[6]  = '{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    vec[7]  = '{3'd5, 32'h0000_0FFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    vec[8]  = '{3'd5, 32'h0000_1000, 32'h0000_0013, 32'h0000_0013, 1'b1};
    vec[9]  = '{3'd2, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0};
    vec[10] = '{3'd7, 32'h0000_1FFE, 32'h0000_0063, 32'hFE00_0FE3, 1'b0};
    vec[11] = '{3'd6, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b0};
    vec[12] = '{3'd1, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1};
    vec[13] = '{3'd4, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1};
    vec[14] = '{3'd7, 32'h0000_2000, 32'h0000_0063, 32'h0000_0063, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    imm_sel = 3'd0; imm = '0; base_instr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst range_err", {31'd0, range_err}, 32'd0);
    chk("rst err_count", {28'd0, err_count}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);

    // Single requests: fixed two-edge latency, packing, range flag, counter.
    exp_cnt = 0;
    foreach (vec[i]) begin
      @(negedge clk);
      in_valid = 1'b1; imm_sel = vec[i].sel; imm = vec[i].imm; base_instr = vec[i].base;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d early valid", i), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d instr", i), instr, vec[i].exp_instr);
      chk($sformatf("v%0d range_err", i), {31'd0, range_err}, {31'd0, vec[i].exp_err});
      if (!vec[i].exp_err)
        chk($sformatf("v%0d reext", i), reext(instr, vec[i].sel), vec[i].imm);
      else
        exp_cnt++;
      @(negedge clk);
      chk($sformatf("v%0d drained", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d err_count", i), {28'd0, err_count}, exp_cnt[31:0]);
    end

    // Back-to-back stream of 8 with a 3-cycle consumer stall.
    sent = 0; got = 0; prev_stall = 0; saw_full = 0; prev = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready  = !(cyc >= 4 && cyc <= 6);
      in_valid   = (sent < 8);
      imm_sel    = 3'd0;
      imm        = 32'(sent + 1);
      base_instr = 32'h13;
      #1;
      if (prev_stall) begin
        chk("stall valid hold", {31'd0, out_valid}, 32'd1);
        chk("stall instr hold", instr, prev);
      end
      if (!in_ready) saw_full = 1;
      if (out_valid && out_ready) begin
        chk($sformatf("stream item %0d", got), instr, (32'(got + 1) << 20) | 32'h13);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev       = instr;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream count", got, 32'd8);
    chk("stream in_ready low when full", {31'd0, saw_full}, 32'd1);

    // Saturation at all-ones, then clear coinciding with a delivered error.
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    chk("clr alone", {28'd0, err_count}, 32'd0);
    send_errs(15);
    chk("cnt at 15", {28'd0, err_count}, 32'hF);
    send_errs(1);
    chk("cnt saturated", {28'd0, err_count}, 32'hF);
    @(negedge clk);
    in_valid = 1'b1; imm_sel = 3'd2; imm = 32'h0000_0003; base_instr = 32'h63;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr race err", {31'd0, out_valid & range_err}, 32'd1);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr wins", {28'd0, err_count}, 32'd0);
    send_errs(1);
    chk("cnt after clr", {28'd0, err_count}, 32'd1);

    // Reset with both stages full discards everything in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; imm_sel = 3'd5; imm = 32'h0000_1000; base_instr = 32'h13;
    @(negedge clk);
    imm = 32'h0000_2000;
    @(negedge clk);
    #1;
    chk("full in_ready", {31'd0, in_ready}, 32'd0);
    chk("full out_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst err_count", {28'd0, err_count}, 32'd0);
    chk("midrst instr", instr, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post rst in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("no stale %0d", k), {31'd0, out_valid}, 32'd0);
    end
    chk("post rst err_count", {28'd0, err_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
